// File: rtl/shmem_core_port.sv
// Per-core front end to shared memory: buffers byte load/store requests, drives one
// bank arbiter strobe at a time and returns read data or a timeout error.
module shmem_core_port #(
  parameter int NUM_BANKS  = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [11:0]            req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   resp_valid,
  output logic [7:0]             resp_rdata,
  output logic                   resp_err,
  output logic [NUM_BANKS-1:0]   bank_read,
  output logic [NUM_BANKS-1:0]   bank_write,
  output logic [11:0]            bank_addr,
  output logic [7:0]             bank_wdata,
  input  logic [NUM_BANKS-1:0]   bank_finish,
  input  logic [8*NUM_BANKS-1:0] bank_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } req_t;

  state_t          state, state_n;
  req_t            mem [FIFO_DEPTH];
  req_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            push, pop;
  logic [7:0]      timer, timer_n;
  logic [3:0]      sel;
  logic            finish_hit, timeout_hit;

  logic [NUM_BANKS-1:0] rd_n, wr_n;
  logic [11:0]          addr_n;
  logic [7:0]           wdata_n, rdata_n;
  logic                 rv_n, err_n;

  assign req_ready   = (count != (PW+1)'(FIFO_DEPTH));
  assign push        = req_valid && req_ready;
  assign head        = mem[rd_ptr];
  assign sel         = bank_addr[11:8];
  assign finish_hit  = bank_finish[sel];
  assign timeout_hit = (timer == 8'(TIMEOUT - 1));
  assign pop         = (state == BUSY) && (finish_hit || timeout_hit);

  // The head entry stays in the buffer until its response, so pop coincides with finish/timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bank_read  <= '0;
      bank_write <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bank_read  <= rd_n;
      bank_write <= wr_n;
      bank_addr  <= addr_n;
      bank_wdata <= wdata_n;
      resp_valid <= rv_n;
      resp_err   <= err_n;
      resp_rdata <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (count != '0) state_n = BUSY;
      BUSY:    if (finish_hit || timeout_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; finish takes priority over timeout.
  always_comb begin
    rd_n    = bank_read;
    wr_n    = bank_write;
    addr_n  = bank_addr;
    wdata_n = bank_wdata;
    timer_n = timer;
    rv_n    = 1'b0;
    err_n   = 1'b0;
    rdata_n = '0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          rd_n    = '0;
          wr_n    = '0;
          addr_n  = head.addr;
          wdata_n = head.wdata;
          timer_n = '0;
          if (head.we) wr_n[head.addr[11:8]] = 1'b1;
          else         rd_n[head.addr[11:8]] = 1'b1;
        end
      end
      BUSY: begin
        if (finish_hit) begin
          rd_n  = '0;
          wr_n  = '0;
          rv_n  = 1'b1;
          if (|bank_read) rdata_n = bank_rdata[{sel, 3'b000} +: 8];
        end else if (timeout_hit) begin
          rd_n  = '0;
          wr_n  = '0;
          rv_n  = 1'b1;
          err_n = 1'b1;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shmem_core_port.sv
// Bench for shmem_core_port: transaction-level model of the request queue and bank
// responder, directed vectors, multi-cycle corner sequences and a randomized phase.
module tb_shmem_core_port;

  localparam int NB = 16;
  localparam int FD = 2;
  localparam int TO = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           req_valid, req_ready, req_we;
  logic [11:0]    req_addr;
  logic [7:0]     req_wdata;
  logic           resp_valid, resp_err;
  logic [7:0]     resp_rdata;
  logic [NB-1:0]  bank_read, bank_write, bank_finish;
  logic [11:0]    bank_addr;
  logic [7:0]     bank_wdata;
  logic [8*NB-1:0] bank_rdata;
  logic [NB-1:0]  auto_finish, stray_mask;

  assign bank_finish = auto_finish | stray_mask;

  always #5 clock = ~clock;

  shmem_core_port #(.NUM_BANKS(NB), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bank_read(bank_read), .bank_write(bank_write),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_finish(bank_finish), .bank_rdata(bank_rdata)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          acc_cyc;
  } mreq_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         dur;
  } mrsp_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_dur;
  } vec_t;

  mreq_t exp_req[$];
  mrsp_t exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, occ = 0, hi_cnt = 0, cur_lat = 0, next_lat = 1;
  int last_resp_cyc = -100, resp_cnt = 0, last_dur = 0;
  bit rand_lat = 0, inflight = 0, prev_rv = 0, got_acc = 0;
  logic [15:0] issue_rd, issue_wr;
  logic [11:0] issue_addr;
  logic [7:0]  last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bank responder and scoreboard, evaluated 1 time unit after each rising edge.
  task automatic monitor();
    logic [15:0] strobe;
    mrsp_t e;
    mreq_t q;
    int b, want;
    strobe = bank_read | bank_write;
    if (resp_valid) begin
      resp_cnt++;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      last_dur   = hi_cnt;
      check("resp_pulse_width", 64'(prev_rv), 0);
      check("strobe_clear_on_resp", 64'(strobe), 0);
      if (exp_rsp.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        e = exp_rsp.pop_front();
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_err", 64'(resp_err), 64'(e.err));
        check("strobe_cycles", 64'(hi_cnt), 64'(e.dur));
        occ--;
      end
      inflight = 0;
      last_resp_cyc = cyc;
    end else begin
      check("resp_idle", 64'({resp_err, resp_rdata}), 0);
    end
    if (strobe != '0 && !inflight) begin
      inflight = 1;
      hi_cnt = 0;
      issue_rd = bank_read;
      issue_wr = bank_write;
      issue_addr = bank_addr;
      if (exp_req.size() == 0) check("unexpected_issue", 1, 0);
      else begin
        q = exp_req.pop_front();
        b = int'(q.addr[11:8]);
        want = (q.acc_cyc + 1 > last_resp_cyc + 2) ? q.acc_cyc + 1 : last_resp_cyc + 2;
        check("issue_cycle", 64'(cyc), 64'(want));
        check("issue_addr", 64'(bank_addr), 64'(q.addr));
        check("issue_wdata", 64'(bank_wdata), 64'(q.wdata));
        check("issue_read", 64'(bank_read), q.we ? 64'(0) : 64'(16'h1 << b));
        check("issue_write", 64'(bank_write), q.we ? 64'(16'h1 << b) : 64'(0));
        cur_lat = rand_lat ? int'($urandom_range(0, 10)) : next_lat;
        e.err   = (cur_lat == 0 || cur_lat > TO);
        e.dur   = e.err ? TO : cur_lat;
        e.rdata = (e.err || q.we) ? 8'h00 : bank_rdata[8*b +: 8];
        exp_rsp.push_back(e);
      end
    end
    if (strobe != '0) begin
      check("strobe_hold", {20'h0, bank_read, bank_write, bank_addr}, {20'h0, issue_rd, issue_wr, issue_addr});
      hi_cnt++;
      auto_finish = (hi_cnt == cur_lat) ? strobe : '0;
    end else begin
      check("strobe_dropped", 64'(inflight), 0);
      hi_cnt = 0;
      auto_finish = '0;
    end
    check("req_ready", 64'(req_ready), 64'(occ < FD));
    prev_rv = resp_valid;
  endtask

  task automatic tick();
    mreq_t r;
    bit acc;
    acc = req_valid && !reset && (occ < FD);
    r = '{req_we, req_addr, req_wdata, cyc + 1};
    @(posedge clock);
    #1;
    cyc++;
    got_acc = acc;
    if (reset) begin
      exp_req.delete();
      exp_rsp.delete();
      occ = 0;
      inflight = 0;
      hi_cnt = 0;
      auto_finish = '0;
      prev_rv = 0;
    end else begin
      if (acc) begin
        exp_req.push_back(r);
        occ++;
      end
      monitor();
    end
  endtask

  task automatic send(input logic we, input logic [11:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    got_acc   = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (got_acc) break;
    end
    if (!got_acc) check("send_accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    for (int i = 0; i < budget && resp_cnt < target; i++) tick();
    if (resp_cnt < target) check("resp_wait_timeout", 64'(resp_cnt), 64'(target));
  endtask

  vec_t vecs[7];
  int   base;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    auto_finish = '0;
    stray_mask = '0;
    bank_rdata = '0;
    bank_rdata[7:0]     = 8'h11;
    bank_rdata[23:16]   = 8'h33;
    bank_rdata[31:24]   = 8'h5C;
    bank_rdata[47:40]   = 8'hA7;
    bank_rdata[127:120] = 8'hE1;

    vecs[0] = '{1'b1, 12'h3A5, 8'h5C, 4, 16'h0000, 16'h0008, 8'h00, 1'b0, 4};
    vecs[1] = '{1'b0, 12'h3A5, 8'h00, 4, 16'h0008, 16'h0000, 8'h5C, 1'b0, 4};
    vecs[2] = '{1'b0, 12'h2A0, 8'h00, 0, 16'h0004, 16'h0000, 8'h00, 1'b1, 8};
    vecs[3] = '{1'b0, 12'h512, 8'h00, 8, 16'h0020, 16'h0000, 8'hA7, 1'b0, 8};
    vecs[4] = '{1'b1, 12'hF00, 8'h99, 1, 16'h0000, 16'h8000, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b0, 12'h0FF, 8'h00, 9, 16'h0001, 16'h0000, 8'h00, 1'b1, 8};
    vecs[6] = '{1'b0, 12'hF3C, 8'h00, 2, 16'h8000, 16'h0000, 8'hE1, 1'b0, 2};

    tick();
    tick();
    check("reset_outputs", {2'b0, bank_read, bank_write, bank_addr, bank_wdata, resp_valid, resp_err, resp_rdata}, 0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'(req_ready), 1);

    for (int i = 0; i < 7; i++) begin
      next_lat = vecs[i].lat;
      base = resp_cnt;
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_count(base + 1, 40);
      check($sformatf("vec%0d_read", i), 64'(issue_rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_write", i), 64'(issue_wr), 64'(vecs[i].exp_wr));
      check($sformatf("vec%0d_addr", i), 64'(issue_addr), 64'(vecs[i].addr));
      check($sformatf("vec%0d_rdata", i), 64'(last_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 64'(last_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_cycles", i), 64'(last_dur), 64'(vecs[i].exp_dur));
      tick();
    end

    // Buffer full: third request waits until the first completes.
    next_lat = 6;
    base = resp_cnt;
    send(1'b0, 12'hF01, 8'h00);
    send(1'b0, 12'hF02, 8'h00);
    check("ready_when_full", 64'(req_ready), 0);
    send(1'b0, 12'hF03, 8'h00);
    wait_count(base + 3, 80);
    check("full_drained", 64'(exp_req.size() + exp_rsp.size()), 0);

    // Stray finish on another bank, then finish coinciding with the timeout edge.
    stray_mask = 16'h0040;
    next_lat = TO;
    base = resp_cnt;
    send(1'b0, 12'h512, 8'h00);
    tick();
    tick();
    tick();
    check("stray_still_busy", 64'(bank_read), 64'(16'h0020));
    stray_mask = '0;
    wait_count(base + 1, 40);
    check("simul_err", 64'(last_err), 0);
    check("simul_rdata", 64'(last_rdata), 64'(8'hA7));

    // Back-to-back reads to banks 0, 1, 2.
    next_lat = 1;
    base = resp_cnt;
    send(1'b0, 12'h010, 8'h00);
    send(1'b0, 12'h120, 8'h00);
    send(1'b0, 12'h230, 8'h00);
    wait_count(base + 3, 60);
    check("b2b_last_rdata", 64'(last_rdata), 64'(8'h33));
    tick();

    // Reset while busy with one buffered request.
    next_lat = 0;
    send(1'b0, 12'h140, 8'h00);
    send(1'b1, 12'h777, 8'h42);
    check("midop_busy", 64'(bank_read), 64'(16'h0002));
    reset = 1'b1;
    tick();
    check("midop_reset_outputs", {2'b0, bank_read, bank_write, bank_addr, bank_wdata, resp_valid, resp_err, resp_rdata}, 0);
    reset = 1'b0;
    base = resp_cnt;
    tick();
    check("midop_ready", 64'(req_ready), 1);
    repeat (20) tick();
    check("midop_no_resp", 64'(resp_cnt), 64'(base));

    // Randomized traffic against the model.
    rand_lat = 1;
    bank_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 12'($urandom());
      req_wdata = 8'($urandom());
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 200 && (exp_req.size() + exp_rsp.size()) != 0; i++) tick();
    check("rand_drained", 64'(exp_req.size() + exp_rsp.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
